// File: rtl/pin_scan_announcer.sv
// Pin-scan sequencer: selects one BGA ball at a time and announces its name as an ASCII
// line over a four-phase UART handshake. Define PIN_SCAN_IDX_PREFIX_EN to prefix "NN:".
module pin_scan_announcer #(
   parameter int                       NUM_PINS     = 8,
   parameter int                       DWELL_CYCLES = 25000000,
   parameter logic [NUM_PINS*10-1:0]   BALL_TABLE   = '0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                enable_i,
   output logic [NUM_PINS-1:0] pin_sel_o,
   output logic [6:0]          pin_idx_o,
   output logic                busy_o,
   output logic [7:0]          tx_byte_o,
   output logic                tx_send_o,
   input  logic                tx_ack_i
);

   localparam int             CNT_W      = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [6:0]     IDX_LAST   = 7'(NUM_PINS - 1);
`ifdef PIN_SCAN_IDX_PREFIX_EN
   localparam int             PRE        = 3;
`else
   localparam int             PRE        = 0;
`endif

   typedef enum logic [2:0] {
      IDLE, SELECT, LOAD, REQ, WAIT_ACK, WAIT_REL, DWELL
   } state_t;

   state_t                 state, state_nxt;
   logic                   ack_meta, ack_sync;
   logic [CNT_W-1:0]       dwell_cnt;
   logic                   dwell_over;
   logic [2:0]             byte_cnt;
   logic                   msg_done;
   logic [NUM_PINS*10-1:0] table_shift;
   logic [4:0]             row, col;
   logic [7:0]             msg [0:7];
   logic [2:0]             last_pos;
   logic [NUM_PINS-1:0]    onehot;

   function automatic logic [7:0] ascii_digit(input logic [3:0] d);
      return 8'h30 + {4'h0, d};
   endfunction

   assign dwell_over = (dwell_cnt == DWELL_LAST);

   // Whole line for the current ball, rebuilt combinationally from the table entry.
   always_comb begin
      table_shift = BALL_TABLE >> (10 * pin_idx_o);
      row         = table_shift[9:5];
      col         = table_shift[4:0];
      for (int k = 0; k < 8; k++) msg[k] = 8'h00;
`ifdef PIN_SCAN_IDX_PREFIX_EN
      msg[0] = ascii_digit(4'(pin_idx_o / 7'd10));
      msg[1] = ascii_digit(4'(pin_idx_o % 7'd10));
      msg[2] = 8'h3A;
`endif
      msg[PRE] = (row >= 5'd1 && row <= 5'd26) ? (8'h40 + {3'b000, row}) : 8'h3F;
      if (col == 5'd0) begin
         msg[PRE+1] = 8'h3F;
         msg[PRE+2] = 8'h0D;
         msg[PRE+3] = 8'h0A;
         last_pos   = 3'(PRE + 3);
      end else if (col < 5'd10) begin
         msg[PRE+1] = ascii_digit(4'(col));
         msg[PRE+2] = 8'h0D;
         msg[PRE+3] = 8'h0A;
         last_pos   = 3'(PRE + 3);
      end else begin
         msg[PRE+1] = ascii_digit(4'(col / 5'd10));
         msg[PRE+2] = ascii_digit(4'(col % 5'd10));
         msg[PRE+3] = 8'h0D;
         msg[PRE+4] = 8'h0A;
         last_pos   = 3'(PRE + 4);
      end
   end

   always_comb begin
      onehot = '0;
      for (int k = 0; k < NUM_PINS; k++) onehot[k] = (pin_idx_o == 7'(k));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (enable_i) state_nxt = SELECT;
         SELECT:   state_nxt = LOAD;
         LOAD:     state_nxt = msg_done ? DWELL : REQ;
         // A stale ack left over from before a reset must clear before a new request.
         REQ:      if (!ack_sync) state_nxt = WAIT_ACK;
         WAIT_ACK: if (ack_sync) state_nxt = WAIT_REL;
         WAIT_REL: if (!ack_sync) state_nxt = LOAD;
         DWELL:    if (dwell_over) state_nxt = enable_i ? SELECT : IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_meta  <= 1'b0;
         ack_sync  <= 1'b0;
         dwell_cnt <= '0;
         byte_cnt  <= '0;
         msg_done  <= 1'b0;
         pin_sel_o <= '0;
         pin_idx_o <= '0;
         busy_o    <= 1'b0;
         tx_byte_o <= 8'h00;
         tx_send_o <= 1'b0;
      end else begin
         ack_meta <= tx_ack_i;
         ack_sync <= ack_meta;
         if (!dwell_over) dwell_cnt <= dwell_cnt + CNT_W'(1);
         case (state)
            SELECT: begin
               pin_sel_o <= onehot;
               busy_o    <= 1'b1;
               dwell_cnt <= '0;
               byte_cnt  <= '0;
               msg_done  <= 1'b0;
            end
            // msg_done flags the final byte so a full 8-byte line survives the 3-bit counter wrap.
            LOAD: if (!msg_done) begin
               tx_byte_o <= msg[byte_cnt];
               byte_cnt  <= byte_cnt + 3'd1;
               msg_done  <= (byte_cnt == last_pos);
            end
            REQ:      if (!ack_sync) tx_send_o <= 1'b1;
            WAIT_ACK: if (ack_sync) tx_send_o <= 1'b0;
            DWELL: if (dwell_over) begin
               if (enable_i) begin
                  pin_idx_o <= (pin_idx_o == IDX_LAST) ? 7'd0 : pin_idx_o + 7'd1;
               end else begin
                  pin_idx_o <= 7'd0;
                  pin_sel_o <= '0;
                  busy_o    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pin_scan_announcer.sv
// Bench for pin_scan_announcer: a 3-pin scanner and a 1-pin scanner, each with a 4-cycle
// ack responder; captured lines are compared against hand-written expected bytes.
module tb_pin_scan_announcer;

   typedef struct {
      int          inst;
      logic [6:0]  idx;
      logic [7:0]  sel;
      logic [63:0] bytes;
      int          len;
   } line_rec_t;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic       rst_a_n = 1'b0, en_a = 1'b0, ack_a = 1'b0;
   logic       rst_b_n = 1'b0, en_b = 1'b0, ack_b = 1'b0, stall_b = 1'b0;
   logic [2:0] sel_a;
   logic [0:0] sel_b;
   logic [6:0] idx_a, idx_b;
   logic       busy_a, busy_b, send_a, send_b;
   logic [7:0] byte_a, byte_b;

   pin_scan_announcer #(
      .NUM_PINS(3), .DWELL_CYCLES(2000),
      .BALL_TABLE({5'd20, 5'd6, 5'd4, 5'd13, 5'd3, 5'd4})
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_a_n), .enable_i(en_a), .pin_sel_o(sel_a), .pin_idx_o(idx_a),
      .busy_o(busy_a), .tx_byte_o(byte_a), .tx_send_o(send_a), .tx_ack_i(ack_a)
   );

   pin_scan_announcer #(
      .NUM_PINS(1), .DWELL_CYCLES(10), .BALL_TABLE({5'd14, 5'd5})
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_b_n), .enable_i(en_b), .pin_sel_o(sel_b), .pin_idx_o(idx_b),
      .busy_o(busy_b), .tx_byte_o(byte_b), .tx_send_o(send_b), .tx_ack_i(ack_b)
   );

   int checks = 0, errors = 0;
   int onehot_err = 0, stable_err = 0, stall_err = 0;
   int hold_a = 0, min_hold_a = 1000000;

   // Transmitter models: ack rises 4 cycles after a request, falls 4 cycles after release.
   always begin
      @(negedge clk);
      if (send_a && !ack_a) begin repeat (3) @(negedge clk); ack_a = 1'b1; end
      else if (!send_a && ack_a) begin repeat (3) @(negedge clk); ack_a = 1'b0; end
   end
   always begin
      @(negedge clk);
      if (send_b && !ack_b && !stall_b) begin repeat (3) @(negedge clk); ack_b = 1'b1; end
      else if (!send_b && ack_b) begin repeat (3) @(negedge clk); ack_b = 1'b0; end
   end

   logic [22:0] buf_a [0:255];
   logic [22:0] buf_b [0:255];
   int   wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
   logic cap_a = 1'b0, cap_b = 1'b0;
   always @(negedge clk) begin
      if (send_a && !cap_a) begin buf_a[wr_a[7:0]] = {byte_a, idx_a, 5'b0, sel_a}; wr_a++; end
      cap_a = send_a;
   end
   always @(negedge clk) begin
      if (send_b && !cap_b) begin buf_b[wr_b[7:0]] = {byte_b, idx_b, 7'b0, sel_b}; wr_b++; end
      cap_b = send_b;
   end

   logic [2:0] prev_sel_a = '0;
   logic [7:0] prev_byte_a = '0, prev_byte_b = '0;
   logic       prev_send_a = 1'b0, prev_send_b = 1'b0;
   always @(negedge clk) begin
      if (busy_a && !$onehot(sel_a)) onehot_err++;
      if (busy_b && !$onehot(sel_b)) onehot_err++;
      if (rst_a_n && (send_a || prev_send_a) && byte_a != prev_byte_a) stable_err++;
      if (rst_b_n && (send_b || prev_send_b) && byte_b != prev_byte_b) stable_err++;
      if (rst_a_n && sel_a != prev_sel_a) begin
         if (prev_sel_a != 3'b000 && sel_a != 3'b000 && hold_a < min_hold_a) min_hold_a = hold_a;
         hold_a = 1;
      end else hold_a++;
      prev_sel_a  = sel_a;
      prev_byte_a = byte_a;
      prev_byte_b = byte_b;
      prev_send_a = send_a;
      prev_send_b = send_b;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic get_line(input int inst, output logic [63:0] val, output int n,
                           output logic [6:0] li, output logic [7:0] ls);
      logic [22:0] e;
      int cyc;
      bit done, got;
      val = '0; n = 0; li = '0; ls = '0; cyc = 0; done = 0;
      while (!done && cyc < 6000) begin
         got = 0;
         if (inst == 0 && rd_a != wr_a) begin e = buf_a[rd_a[7:0]]; rd_a++; got = 1; end
         else if (inst == 1 && rd_b != wr_b) begin e = buf_b[rd_b[7:0]]; rd_b++; got = 1; end
         if (got) begin
            if (n == 0) begin li = e[14:8]; ls = e[7:0]; end
            val = {val[55:0], e[22:15]};
            n++;
            if (e[22:15] == 8'h0A || n == 8) done = 1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   task automatic check_line(input string tag, input line_rec_t r);
      logic [63:0] v;
      int n;
      logic [6:0] li;
      logic [7:0] ls;
      get_line(r.inst, v, n, li, ls);
      check({tag, " bytes"}, v, r.bytes);
      check({tag, " len"}, 64'(n), 64'(r.len));
      check({tag, " idx"}, 64'(li), 64'(r.idx));
      check({tag, " sel"}, 64'(ls), 64'(r.sel));
   endtask

   line_rec_t recs [0:4];
   int        cyc;
   logic [7:0] first_a, first_b;

   initial begin
`ifdef PIN_SCAN_IDX_PREFIX_EN
      recs[0] = '{0, 7'd0, 8'b001, 64'h0030_303A_4334_0D0A, 7};
      recs[1] = '{0, 7'd1, 8'b010, 64'h3031_3A44_3133_0D0A, 8};
      recs[2] = '{0, 7'd2, 8'b100, 64'h0030_323A_5436_0D0A, 7};
      recs[4] = '{1, 7'd0, 8'b1,   64'h0030_303A_4E35_0D0A, 7};
`else
      recs[0] = '{0, 7'd0, 8'b001, 64'h4334_0D0A, 4};
      recs[1] = '{0, 7'd1, 8'b010, 64'h44_3133_0D0A, 5};
      recs[2] = '{0, 7'd2, 8'b100, 64'h5436_0D0A, 4};
      recs[4] = '{1, 7'd0, 8'b1,   64'h4E35_0D0A, 4};
`endif
      recs[3] = recs[0];
      first_a = 8'(recs[0].bytes >> (8 * (recs[0].len - 1)));
      first_b = 8'(recs[4].bytes >> (8 * (recs[4].len - 1)));

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      @(negedge clk);
      check("reset_a", {sel_a, idx_a, busy_a, byte_a, send_a}, 64'd0);
      check("reset_b", {sel_b, idx_b, busy_b, byte_b, send_b}, 64'd0);

      // Start-up latency: enable sampled at edge n.
      en_a = 1'b1;
      @(posedge clk); @(negedge clk);
      check("lat_n busy", 64'(busy_a), 64'd0);
      @(posedge clk); @(negedge clk);
      check("lat_n1 sel_busy", {sel_a, busy_a}, {3'b001, 1'b1});
      check("lat_n1 send", 64'(send_a), 64'd0);
      @(posedge clk); @(negedge clk);
      check("lat_n2 send", 64'(send_a), 64'd0);
      @(posedge clk); @(negedge clk);
      check("lat_n3 send", 64'(send_a), 64'd1);
      check("lat_n3 byte", 64'(byte_a), 64'(first_a));

      for (int i = 0; i < 4; i++) check_line($sformatf("a_line%0d", i), recs[i]);

      // Drop enable during the second byte of the next line.
      cyc = 0;
      while (wr_a < rd_a + 2 && cyc < 5000) begin @(negedge clk); cyc++; end
      check("drop second byte seen", 64'(wr_a >= rd_a + 2), 64'd1);
      en_a = 1'b0;
      check_line("a_drop_line", recs[1]);
      check("drop busy before exit", {sel_a, busy_a}, {3'b010, 1'b1});
      cyc = 0;
      while (busy_a && cyc < 4000) begin @(negedge clk); cyc++; end
      check("drop idle", {sel_a, busy_a}, 64'd0);
      repeat (40) @(negedge clk);
      check("drop no new line", 64'(wr_a), 64'(rd_a));

      // Asynchronous reset while a request is outstanding.
      en_a = 1'b1;
      cyc = 0;
      while (!send_a && cyc < 50) begin @(negedge clk); cyc++; end
      check("rst req seen", 64'(send_a), 64'd1);
      @(posedge clk);
      #5 rst_a_n = 1'b0;
      #1 check("rst async", {sel_a, idx_a, busy_a, byte_a, send_a}, 64'd0);
      repeat (12) @(negedge clk);
      rd_a = wr_a;
      rst_a_n = 1'b1;
      check_line("a_restart", recs[0]);

      // Stalled transmitter on the 1-pin scanner.
      stall_b = 1'b1;
      en_b = 1'b1;
      cyc = 0;
      while (!send_b && cyc < 50) begin @(negedge clk); cyc++; end
      check("stall first byte", {send_b, byte_b}, {1'b1, first_b});
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (!send_b || byte_b != first_b || idx_b != 7'd0 || sel_b != 1'b1) stall_err++;
      end
      check("stall hold", 64'(stall_err), 64'd0);
      stall_b = 1'b0;
      cyc = 0;
      while (!ack_b && cyc < 100) begin @(posedge clk); cyc++; end
      @(negedge clk);
      check("ack edge1 send", 64'(send_b), 64'd1);
      @(posedge clk); @(negedge clk);
      check("ack edge2 send", 64'(send_b), 64'd1);
      @(posedge clk); @(negedge clk);
      check("ack edge3 send", 64'(send_b), 64'd0);
      check_line("b_line0", recs[4]);
      check_line("b_line1", recs[4]);
      en_b = 1'b0;
      cyc = 0;
      while (busy_b && cyc < 500) begin @(negedge clk); cyc++; end
      check("b idle", {sel_b, busy_b}, 64'd0);

      check("onehot while busy", 64'(onehot_err), 64'd0);
      check("byte stable while send", 64'(stable_err), 64'd0);
      check("min pin hold in range", 64'(min_hold_a >= 2000 && min_hold_a <= 2002), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
